// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, shamt/immediate
// operand selection and load-use hazard detection feeding the EX-stage ALU.
module idex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] IdRsData,
   input  logic [DATA_W-1:0] IdRtData,
   input  logic [DATA_W-1:0] IdImm,
   input  logic [4:0]        IdShamt,
   input  logic [RA_W-1:0]   IdRs,
   input  logic [RA_W-1:0]   IdRt,
   input  logic [RA_W-1:0]   IdRd,
   input  logic              IdUsesRt,
   input  logic [3:0]        IdALUCtrl,
   input  logic              IdALUSrc,
   input  logic              IdShiftSrc,
   input  logic              IdRegDst,
   input  logic              IdRegWrite,
   input  logic              IdMemRead,
   input  logic              IdMemWrite,
   input  logic              IdMemToReg,
   input  logic              Flush,
   input  logic              Hold,
   input  logic              ExMemRegWrite,
   input  logic [RA_W-1:0]   ExMemRw,
   input  logic [DATA_W-1:0] ExMemResult,
   input  logic              MemWbRegWrite,
   input  logic [RA_W-1:0]   MemWbRw,
   input  logic [DATA_W-1:0] MemWbData,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic [3:0]        ALUCtrl,
   output logic [DATA_W-1:0] StoreData,
   output logic [RA_W-1:0]   ExRw,
   output logic              ExRegWrite,
   output logic              ExMemRead,
   output logic              ExMemWrite,
   output logic              ExMemToReg,
   output logic              ExValid,
   output logic              LoadUseStall
);

   typedef struct packed {
      logic [DATA_W-1:0] RsData;
      logic [DATA_W-1:0] RtData;
      logic [DATA_W-1:0] Imm;
      logic [4:0]        Shamt;
      logic [RA_W-1:0]   Rs;
      logic [RA_W-1:0]   Rt;
      logic [RA_W-1:0]   Rw;
      logic [3:0]        ALUCtrl;
      logic              ALUSrc;
      logic              ShiftSrc;
      logic              RegWrite;
      logic              MemRead;
      logic              MemWrite;
      logic              MemToReg;
      logic              Valid;
   } stage_t;

   stage_t stage_d, stage_q;

   logic [DATA_W-1:0] fwdA, fwdB;

   always_comb begin
      LoadUseStall = stage_q.Valid & stage_q.MemRead & (stage_q.Rw != '0) &
                     ((stage_q.Rw == IdRs) | (IdUsesRt & (stage_q.Rw == IdRt)));
   end

   // A bubble clears everything, so a squashed slot cannot forward or drive the ALU.
   always_comb begin
      stage_d = stage_q;
      if (Flush) begin
         stage_d = '0;
      end else if (!Hold) begin
         if (LoadUseStall) begin
            stage_d = '0;
         end else begin
            stage_d.RsData   = IdRsData;
            stage_d.RtData   = IdRtData;
            stage_d.Imm      = IdImm;
            stage_d.Shamt    = IdShamt;
            stage_d.Rs       = IdRs;
            stage_d.Rt       = IdRt;
            stage_d.Rw       = IdRegDst ? IdRd : IdRt;
            stage_d.ALUCtrl  = IdALUCtrl;
            stage_d.ALUSrc   = IdALUSrc;
            stage_d.ShiftSrc = IdShiftSrc;
            stage_d.RegWrite = IdRegWrite;
            stage_d.MemRead  = IdMemRead;
            stage_d.MemWrite = IdMemWrite;
            stage_d.MemToReg = IdMemToReg;
            stage_d.Valid    = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // The younger EX/MEM result wins over MEM/WB; register 0 is hardwired and never forwarded.
   always_comb begin
      fwdA = stage_q.RsData;
      if (ExMemRegWrite && (ExMemRw != '0) && (ExMemRw == stage_q.Rs)) begin
         fwdA = ExMemResult;
      end else if (MemWbRegWrite && (MemWbRw != '0) && (MemWbRw == stage_q.Rs)) begin
         fwdA = MemWbData;
      end
      fwdB = stage_q.RtData;
      if (ExMemRegWrite && (ExMemRw != '0) && (ExMemRw == stage_q.Rt)) begin
         fwdB = ExMemResult;
      end else if (MemWbRegWrite && (MemWbRw != '0) && (MemWbRw == stage_q.Rt)) begin
         fwdB = MemWbData;
      end
   end

   always_comb begin
      BusA       = stage_q.ShiftSrc ? {{(DATA_W-5){1'b0}}, stage_q.Shamt} : fwdA;
      BusB       = stage_q.ALUSrc ? stage_q.Imm : fwdB;
      StoreData  = fwdB;
      ALUCtrl    = stage_q.ALUCtrl;
      ExRw       = stage_q.Rw;
      ExRegWrite = stage_q.RegWrite;
      ExMemRead  = stage_q.MemRead;
      ExMemWrite = stage_q.MemWrite;
      ExMemToReg = stage_q.MemToReg;
      ExValid    = stage_q.Valid;
   end

endmodule

// File: doc/idex_operand_stage.md
Name: idex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding for the pipelined MIPS datapath.
- Sits directly upstream of the EX-stage ALU and drives its BusA, BusB and ALUCtrl.
- Captures decoded operands and controls each cycle, resolves EX/MEM and MEM/WB forwarding, and selects the shamt/immediate operands.
- Detects load-use hazards, requests a decode stall, and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width.
- RA_W, 5, register address width.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
IdRsData  in  DATA_W  register-file read data for Rs
IdRtData  in  DATA_W  register-file read data for Rt
IdImm  in  DATA_W  sign/zero-extended immediate
IdShamt  in  5  shift amount field
IdRs  in  RA_W  Rs address
IdRt  in  RA_W  Rt address
IdRd  in  RA_W  Rd address
IdUsesRt  in  1  decode instruction reads Rt as a source
IdALUCtrl  in  4  ALU operation code
IdALUSrc  in  1  1 = BusB takes the immediate
IdShiftSrc  in  1  1 = BusA takes the zero-extended shamt
IdRegDst  in  1  1 = write Rd, 0 = write Rt
IdRegWrite  in  1  writes the register file
IdMemRead  in  1  load instruction
IdMemWrite  in  1  store instruction
IdMemToReg  in  1  writeback selects memory data
Flush  in  1  squash the instruction entering EX (branch/jump)
Hold  in  1  global freeze (memory wait)
ExMemRegWrite  in  1  EX/MEM writes a register
ExMemRw  in  RA_W  EX/MEM destination register
ExMemResult  in  DATA_W  EX/MEM ALU result
MemWbRegWrite  in  1  MEM/WB writes a register
MemWbRw  in  RA_W  MEM/WB destination register
MemWbData  in  DATA_W  MEM/WB writeback data
BusA  out  DATA_W  ALU operand A
BusB  out  DATA_W  ALU operand B
ALUCtrl  out  4  registered ALU opcode
StoreData  out  DATA_W  forwarded Rt value for stores
ExRw  out  RA_W  registered destination register
ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg  out  1 each  registered controls
ExValid  out  1  stage holds a real instruction
LoadUseStall  out  1  combinational; decode and PC must hold

Behaviour:

Registered state:
- RsData_q, RtData_q, Imm_q, Shamt_q, Rs_q, Rt_q and Rw_q, where Rw_q = IdRegDst ? IdRd : IdRt, computed at capture.
- ALUCtrl_q, ALUSrc_q, ShiftSrc_q, the four memory/writeback control bits, and Valid_q.

Reset:
- All registers clear to 0, so every registered output is 0 and ExValid = 0.
- BusA and BusB evaluate to 0.

Per-edge update priority:
- Reset > Flush > Hold > LoadUseStall bubble > normal capture.
- Flush: bubble. Valid_q, RegWrite, MemRead, MemWrite and MemToReg go to 0; ALUCtrl_q and all data/address registers go to 0.
- Hold (no Flush): every register keeps its value.
- LoadUseStall (no Hold/Flush): bubble, identical to Flush. Decode holds the instruction externally, so it re-enters next cycle.
- Otherwise: capture all Id* inputs and set Valid_q = 1.

Load-use detection:
- LoadUseStall = Valid_q & ExMemRead & (Rw_q != 0) & ((Rw_q == IdRs) | (IdUsesRt & (Rw_q == IdRt))).
- The output is combinational and is not masked by Hold; the consumer gates it.

Forwarding:
- Combinational, evaluated from the registered addresses in the EX cycle.
- FwdA:
  - ExMemResult if ExMemRegWrite & ExMemRw != 0 & ExMemRw == Rs_q.
  - Else MemWbData if MemWbRegWrite & MemWbRw != 0 & MemWbRw == Rs_q.
  - Else RsData_q.
- FwdB: the same rule applied to Rt_q and RtData_q.
- EX/MEM always beats MEM/WB. Register 0 is never forwarded.

Operand selection:
- BusA = ShiftSrc_q ? {27'b0, Shamt_q} : FwdA. Shifts in the ALU use BusA as the shift amount.
- BusB = ALUSrc_q ? Imm_q : FwdB.
- StoreData = FwdB regardless of ALUSrc_q.

Latency and timing:
- One cycle: decode inputs sampled at edge N appear on ALUCtrl/Ex* after edge N.
- BusA and BusB follow forwarding inputs within the same cycle.
- No combinational path from Id* inputs to any output except LoadUseStall.

Test Plan:
1. Reset=1 for 2 cycles with random Id* inputs -> all outputs 0, ExValid=0, LoadUseStall=0.
2. Capture ADD with IdRs=3/IdRsData=0x10 and IdRt=4/IdRtData=0x20; ExMemRegWrite=1, ExMemRw=4, ExMemResult=0x99; MemWbRegWrite=1, MemWbRw=4, MemWbData=0x55 -> next cycle BusA=0x10, BusB=0x99 (EX/MEM priority). Drop ExMemRegWrite -> BusB=0x55.
3. Forward target register 0: ExMemRw=0, ExMemRegWrite=1, Rs_q=0, RsData_q=0 -> BusA=0, not ExMemResult.
4. LW capture with Rw_q=8, then decode IdRs=8 -> LoadUseStall=1 that cycle. Next edge ExValid=0 and ExRegWrite=0; the re-presented instruction is captured on the following edge with ExValid=1.
5. Flush=1 and Hold=1 together while an instruction is loaded -> bubble (ExValid=0, ALUCtrl=0). Hold=1 alone for 3 cycles -> all outputs unchanged.
6. SLL (IdShiftSrc=1, IdShamt=5) and ADDI (IdALUSrc=1, IdImm=0xFFFFFFFC) with Rt forwarded = 0x7 -> SLL: BusA=0x5. ADDI: BusB=0xFFFFFFFC, StoreData=0x7.
